game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 213 +++++++++++++++++++++
 tb/tb_game_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Reaction game controller: lights one random target LED per round, scores
// matching switch presses, and counts the game down on the 1 Hz tick.
module game_controller #(
    parameter int          GAME_SECONDS = 60,
    parameter int          ROUND_TICKS  = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [5:0]  timer_out,
    output logic [5:0]  score_out,
    output logic        game_over
);

    localparam logic [5:0] GAME_LEN   = 6'(GAME_SECONDS);
    localparam logic [3:0] ROUND_LAST = 4'(ROUND_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        TARGET  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0]) begin
            return (v >> 1) ^ 16'hB400;
        end else begin
            return v >> 1;
        end
    endfunction

    function automatic logic [3:0] pick_index(input logic [3:0] raw, input logic [3:0] prev);
        return (raw == prev) ? (raw + 4'd1) : raw;
    endfunction

    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : (v + 6'd1);
    endfunction

    state_t      state_r, state_s;
    logic [15:0] led_r, led_s;
    logic [5:0]  timer_r, timer_s;
    logic [5:0]  score_r, score_s;
    logic        over_r, over_s;
    logic [3:0]  round_r, round_s;
    logic [3:0]  prev_r, prev_s;
    logic [15:0] lfsr_r;
    logic        start_q_r;
    logic        start_edge_r;
    logic [3:0]  new_idx_s;
    logic        hit_s;
    logic        last_tick_s;

    assign new_idx_s   = pick_index(lfsr_r[3:0], prev_r);
    assign hit_s       = (sw == led_r);
    assign last_tick_s = tick && (timer_r == 6'd1);

    assign led       = led_r;
    assign timer_out = timer_r;
    assign score_out = score_r;
    assign game_over = over_r;

    // Next-state and next-output decode for the game FSM.
    always_comb begin
        state_s = state_r;
        led_s   = led_r;
        timer_s = timer_r;
        score_s = score_r;
        over_s  = over_r;
        round_s = round_r;
        prev_s  = prev_r;
        case (state_r)
            IDLE: begin
                led_s   = 16'h0000;
                timer_s = GAME_LEN;
                score_s = 6'd0;
                over_s  = 1'b0;
                if (start_edge_r) begin
                    state_s = ARM;
                end else begin
                    state_s = IDLE;
                end
            end
            ARM: begin
                led_s   = 16'h0000;
                timer_s = GAME_LEN;
                score_s = 6'd0;
                over_s  = 1'b0;
                if (sw == 16'h0000) begin
                    state_s = TARGET;
                    led_s   = one_hot(new_idx_s);
                    prev_s  = new_idx_s;
                    round_s = 4'd0;
                end else begin
                    state_s = ARM;
                end
            end
            TARGET: begin
                if (tick) begin
                    timer_s = timer_r - 6'd1;
                end else begin
                    timer_s = timer_r;
                end
                // A hit on the final tick still counts before the game ends.
                if (hit_s) begin
                    score_s = sat_inc(score_r);
                end else begin
                    score_s = score_r;
                end
                if (last_tick_s) begin
                    state_s = DONE;
                    led_s   = 16'hFFFF;
                    timer_s = 6'd0;
                    over_s  = 1'b1;
                end else if (sw != 16'h0000) begin
                    state_s = RELEASE;
                    led_s   = 16'h0000;
                end else if (tick) begin
                    if (round_r == ROUND_LAST) begin
                        led_s   = one_hot(new_idx_s);
                        prev_s  = new_idx_s;
                        round_s = 4'd0;
                    end else begin
                        round_s = round_r + 4'd1;
                    end
                end else begin
                    state_s = TARGET;
                end
            end
            RELEASE: begin
                if (tick) begin
                    timer_s = timer_r - 6'd1;
                end else begin
                    timer_s = timer_r;
                end
                if (last_tick_s) begin
                    state_s = DONE;
                    led_s   = 16'hFFFF;
                    timer_s = 6'd0;
                    over_s  = 1'b1;
                end else if (sw == 16'h0000) begin
                    state_s = TARGET;
                    led_s   = one_hot(new_idx_s);
                    prev_s  = new_idx_s;
                    round_s = 4'd0;
                end else begin
                    state_s = RELEASE;
                end
            end
            DONE: begin
                led_s   = 16'hFFFF;
                timer_s = 6'd0;
                over_s  = 1'b1;
                if (start_edge_r) begin
                    state_s = ARM;
                    led_s   = 16'h0000;
                    timer_s = GAME_LEN;
                    score_s = 6'd0;
                    over_s  = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                led_s   = 16'h0000;
                timer_s = GAME_LEN;
                score_s = 6'd0;
                over_s  = 1'b0;
                round_s = 4'd0;
            end
        endcase
    end

    // State, output, LFSR and start-edge registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            led_r        <= 16'h0000;
            timer_r      <= GAME_LEN;
            score_r      <= 6'd0;
            over_r       <= 1'b0;
            round_r      <= 4'd0;
            prev_r       <= 4'd0;
            lfsr_r       <= LFSR_SEED;
            start_q_r    <= 1'b0;
            start_edge_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            led_r        <= led_s;
            timer_r      <= timer_s;
            score_r      <= score_s;
            over_r       <= over_s;
            round_r      <= round_s;
            prev_r       <= prev_s;
            lfsr_r       <= lfsr_next(lfsr_r);
            start_q_r    <= start;
            start_edge_r <= start & ~start_q_r;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed game scenarios plus random
// play, compared every cycle against a rule-level model of the game.
module tb_game_controller;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_TGT  = 2;
    localparam int P_REL  = 3;
    localparam int P_DONE = 4;

    logic        clk = 1'b0;
    logic        rst, start, tick;
    logic [15:0] sw;
    logic [15:0] led;
    logic [5:0]  timer_out, score_out;
    logic        game_over;

    logic        rst2, start2, tick2;
    logic [15:0] sw2;
    logic [15:0] led2;
    logic [5:0]  timer2, score2;
    logic        over2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          ph;
        int          idx;
        int          prev;
        int          rnd;
        int          tmr;
        int          scr;
        logic [15:0] lf;
        logic        st_q;
        logic        edg;
    } mdl_t;

    mdl_t m, m2;

    always #5 clk = ~clk;

    game_controller dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .sw(sw),
        .led(led), .timer_out(timer_out), .score_out(score_out), .game_over(game_over)
    );

    game_controller #(.GAME_SECONDS(63)) dut63 (
        .clk(clk), .rst(rst2), .start(start2), .tick(tick2), .sw(sw2),
        .led(led2), .timer_out(timer2), .score_out(score2), .game_over(over2)
    );

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic mdl_t mreset(input int gs);
        mdl_t r;
        r.ph = P_IDLE; r.idx = 0; r.prev = 0; r.rnd = 0;
        r.tmr = gs; r.scr = 0; r.lf = 16'hACE1; r.st_q = 1'b0; r.edg = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] mled(input mdl_t x);
        logic [15:0] one;
        one = 16'd1;
        if (x.ph == P_TGT) return one << x.idx;
        if (x.ph == P_DONE) return 16'hFFFF;
        return 16'h0000;
    endfunction

    function automatic mdl_t load(input mdl_t x);
        int i;
        i = int'(x.lf[3:0]);
        if (i == x.prev) i = (i + 1) % 16;
        x.idx = i; x.prev = i; x.rnd = 0; x.ph = P_TGT;
        return x;
    endfunction

    function automatic mdl_t mstep(input mdl_t x, input logic st, input logic tk,
                                   input logic [15:0] s, input int gs, input int rt);
        mdl_t n;
        logic fin;
        n = x;
        fin = tk && (x.tmr == 1);
        case (x.ph)
            P_IDLE: if (x.edg) n.ph = P_ARM;
            P_ARM:  if (s == 16'h0000) n = load(n);
            P_TGT: begin
                if (s == mled(x)) n.scr = (x.scr < 63) ? x.scr + 1 : 63;
                if (tk) n.tmr = x.tmr - 1;
                if (fin) begin
                    n.ph = P_DONE; n.tmr = 0;
                end else if (s != 16'h0000) begin
                    n.ph = P_REL;
                end else if (tk) begin
                    if (x.rnd == rt - 1) n = load(n);
                    else n.rnd = x.rnd + 1;
                end
            end
            P_REL: begin
                if (tk) n.tmr = x.tmr - 1;
                if (fin) begin
                    n.ph = P_DONE; n.tmr = 0;
                end else if (s == 16'h0000) begin
                    n = load(n);
                end
            end
            P_DONE: if (x.edg) begin
                n.ph = P_ARM; n.tmr = gs; n.scr = 0;
            end
            default: ;
        endcase
        n.lf   = galois(x.lf);
        n.st_q = st;
        n.edg  = st & ~x.st_q;
        return n;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("led",        led,                 mled(m));
        cmp("timer",      {10'd0, timer_out},  16'(m.tmr));
        cmp("score",      {10'd0, score_out},  16'(m.scr));
        cmp("game_over",  {15'd0, game_over},  16'(m.ph == P_DONE));
        cmp("led63",      led2,                mled(m2));
        cmp("timer63",    {10'd0, timer2},     16'(m2.tmr));
        cmp("score63",    {10'd0, score2},     16'(m2.scr));
        cmp("game_over63",{15'd0, over2},      16'(m2.ph == P_DONE));
    endtask

    task automatic step();
        @(posedge clk);
        m  = mstep(m,  start,  tick,  sw,  60, 3);
        m2 = mstep(m2, start2, tick2, sw2, 63, 3);
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] prev_led;
        logic [15:0] cur;
        int          t0;
        int          n;

        rst = 1'b0; start = 1'b0; tick = 1'b0; sw = 16'h0000;
        rst2 = 1'b0; start2 = 1'b0; tick2 = 1'b0; sw2 = 16'h0000;
        m  = mreset(60);
        m2 = mreset(63);
        #12;
        check_all();
        rst = 1'b1; rst2 = 1'b1;

        // Start pulse, released switches: ARM then TARGET.
        start = 1'b1;
        step(); step();
        start = 1'b0;
        step();
        cmp("tgt_onehot", 16'($countones(led)), 16'd1);
        cmp("tgt_timer60", {10'd0, timer_out}, 16'd60);

        // Hit then release: score 1, new target differs.
        prev_led = mled(m);
        sw = prev_led;
        step();
        cmp("rel_led_off", led, 16'h0000);
        sw = 16'h0000;
        step();
        cmp("hit_score1", {10'd0, score_out}, 16'd1);
        cmp("new_differs", {15'd0, (led != prev_led)}, 16'd1);

        // Miss: score unchanged, stays in RELEASE while switches held.
        cur = mled(m);
        sw = {cur[10:0], cur[15:11]};
        step(); step(); step();
        cmp("miss_score", {10'd0, score_out}, 16'd1);
        sw = 16'h0000;
        step();

        // Round timeout after three ticks.
        prev_led = mled(m);
        t0 = m.tmr;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        cmp("round_replaced", {15'd0, (led != prev_led)}, 16'd1);
        cmp("timer_minus3", {10'd0, timer_out}, 16'(t0 - 3));

        // Random play, including stray start edges and game completion.
        for (int c = 0; c < 500; c++) begin
            tick  = ($urandom_range(5) == 0);
            start = ($urandom_range(39) == 0);
            cur = mled(m);
            if (m.ph == P_TGT) begin
                n = $urandom_range(7);
                if (n < 3) sw = cur;
                else if (n == 3) begin
                    sw = 16'($urandom());
                    if (sw == cur || sw == 16'h0000) sw = cur ^ 16'h0101;
                end else sw = 16'h0000;
            end else if ($urandom_range(1) == 0) begin
                sw = 16'h0000;
            end else begin
                sw = 16'($urandom());
            end
            step();
        end
        start = 1'b0; tick = 1'b0; sw = 16'h0000;
        step();

        // Run out any game in progress, then restart cleanly.
        n = 0;
        while (m.ph != P_DONE && n < 600) begin
            tick = ~tick; step(); n++;
        end
        tick = 1'b0;
        cmp("reach_done", 16'(m.ph), 16'(P_DONE));
        start = 1'b1; step(); step();
        start = 1'b0; step();
        cmp("restart_score0", {10'd0, score_out}, 16'd0);

        // Full game ending with a hit on the final tick.
        n = 0;
        while (!(m.ph == P_TGT && m.tmr == 1) && n < 400) begin
            tick = ~tick; sw = 16'h0000; step(); n++;
        end
        sw = mled(m); tick = 1'b1;
        step();
        sw = 16'h0000;
        cmp("final_hit_score", {10'd0, score_out}, 16'd1);
        cmp("final_led", led, 16'hFFFF);
        cmp("final_over", {15'd0, game_over}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; step();
        end
        tick = 1'b0;
        cmp("done_timer0", {10'd0, timer_out}, 16'd0);

        // 64 fast hits on the 63-second instance saturate the score.
        start2 = 1'b1; step(); step();
        start2 = 1'b0; step();
        for (int i = 0; i < 64; i++) begin
            sw2 = mled(m2); step();
            sw2 = 16'h0000; step();
        end
        cmp("score_sat", {10'd0, score2}, 16'd63);

        // Asynchronous reset in the middle of TARGET.
        #2;
        rst2 = 1'b0;
        #1;
        m2 = mreset(63);
        check_all();
        cmp("rst_score", {10'd0, score2}, 16'd0);
        #2;
        rst2 = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
